// File: rtl/if_id_queue_pkg.sv
// Shared widths, the NOP encoding and the queue entry type for the fetch/decode queue.
// Build-wide defaults apply unless the macros are already supplied by the project defines.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef NOP_INST
`define NOP_INST 32'h00000013
`endif

package if_id_queue_pkg;
  localparam int DATA_W = `DATA_WIDTH;
  localparam int ADDR_W = `ADDR_WIDTH;
  localparam logic [DATA_W-1:0] NOP_INST = `NOP_INST;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] inst;
  } entry_t;
endpackage

// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue with a valid/ready handshake on both sides and flush on redirect.
// Optional IFQ_BYPASS_EN forwards a fetched word straight to decode while the queue is empty.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [ADDR_W-1:0]            pc_i,
  input  logic [DATA_W-1:0]            inst_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  input  logic                         flush_i,
  output logic [ADDR_W-1:0]            pc_o,
  output logic [DATA_W-1:0]            inst_o,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  entry_t            mem [DEPTH];
  logic [PTR_W-1:0]  wp;
  logic [PTR_W-1:0]  rp;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] pc_last;
  logic              full;
  logic              empty;
  logic              byp;
  logic              push;
  logic              pop;

  // DEPTH need not be a power of two, so wrap explicitly
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

`ifdef IFQ_BYPASS_EN
  assign byp = empty & valid_i & ~flush_i;
`else
  assign byp = 1'b0;
`endif

  // ready_o is purely registered: a full queue refuses a push even on a same-cycle pop
  assign ready_o = ~full;
  assign valid_o = (~empty & ~flush_i) | byp;
  assign pop     = ~empty & ~flush_i & ready_i;
  assign push    = valid_i & ~full & ~flush_i & ~(byp & ready_i);
  assign count_o = count;

  always_comb begin
    inst_o = NOP_INST;
    pc_o   = pc_last;
    if (byp) begin
      inst_o = inst_i;
      pc_o   = pc_i;
    end else if (valid_o) begin
      inst_o = mem[rp].inst;
      pc_o   = mem[rp].pc;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wp      <= '0;
      rp      <= '0;
      count   <= '0;
      pc_last <= '0;
    end else begin
      pc_last <= pc_o;
      if (flush_i) begin
        wp    <= '0;
        rp    <= '0;
        count <= '0;
      end else begin
        if (push) wp <= next_ptr(wp);
        if (pop)  rp <= next_ptr(rp);
        if (push && !pop)      count <= count + 1'b1;
        else if (pop && !push) count <= count - 1'b1;
      end
    end
  end

  // Entry storage is never cleared; occupancy is tracked by count alone
  always_ff @(posedge clk_i) begin
    if (push) mem[wp] <= '{pc: pc_i, inst: inst_i};
  end
endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: DEPTH=2 and DEPTH=3 instances share stimulus and are
// checked against a queue-based model of the fetch/decode handshake rules.
module tb_if_id_queue;
  import if_id_queue_pkg::*;

`ifdef IFQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] inst;
  } ent_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              valid = 1'b0;
  logic              flush = 1'b0;
  logic              rdy = 1'b0;
  logic [ADDR_W-1:0] pc = '0;
  logic [DATA_W-1:0] inst = '0;

  logic              rdy_o0, rdy_o1, val_o0, val_o1;
  logic [ADDR_W-1:0] pc_o0, pc_o1;
  logic [DATA_W-1:0] inst_o0, inst_o1;
  logic [$clog2(3)-1:0] cnt0;
  logic [$clog2(4)-1:0] cnt1;

  logic              o_valid [2];
  logic              o_ready [2];
  logic [31:0]       o_count [2];
  logic [ADDR_W-1:0] o_pc    [2];
  logic [DATA_W-1:0] o_inst  [2];

  logic              e_valid [2];
  logic              e_ready [2];
  logic              e_byp   [2];
  logic [31:0]       e_count [2];
  logic [ADDR_W-1:0] e_pc    [2];
  logic [DATA_W-1:0] e_inst  [2];
  logic [ADDR_W-1:0] m_last  [2];
  ent_t              q0 [$];
  ent_t              q1 [$];
  int                dep [2] = '{2, 3};

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  if_id_queue #(.DEPTH(2)) u_q2 (
    .clk_i(clk), .rst_i(rst), .pc_i(pc), .inst_i(inst), .valid_i(valid),
    .ready_o(rdy_o0), .flush_i(flush), .pc_o(pc_o0), .inst_o(inst_o0),
    .valid_o(val_o0), .ready_i(rdy), .count_o(cnt0)
  );

  if_id_queue #(.DEPTH(3)) u_q3 (
    .clk_i(clk), .rst_i(rst), .pc_i(pc), .inst_i(inst), .valid_i(valid),
    .ready_o(rdy_o1), .flush_i(flush), .pc_o(pc_o1), .inst_o(inst_o1),
    .valid_o(val_o1), .ready_i(rdy), .count_o(cnt1)
  );

  always_comb begin
    o_valid[0] = val_o0;      o_valid[1] = val_o1;
    o_ready[0] = rdy_o0;      o_ready[1] = rdy_o1;
    o_count[0] = 32'(cnt0);   o_count[1] = 32'(cnt1);
    o_pc[0]    = pc_o0;       o_pc[1]    = pc_o1;
    o_inst[0]  = inst_o0;     o_inst[1]  = inst_o1;
  end

  function automatic int msize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  function automatic ent_t mfront(input int k);
    return (k == 0) ? q0[0] : q1[0];
  endfunction

  // Settle combinational outputs and derive what each queue should present now
  task automatic settle();
    #1;
    for (int k = 0; k < 2; k++) begin
      int sz;
      sz = msize(k);
      e_byp[k]   = BYP && (sz == 0) && valid && !flush;
      e_valid[k] = ((sz != 0) && !flush) || e_byp[k];
      e_ready[k] = (sz != dep[k]);
      e_count[k] = 32'(sz);
      if (e_byp[k]) begin
        e_inst[k] = inst;
        e_pc[k]   = pc;
      end else if (e_valid[k]) begin
        e_inst[k] = mfront(k).inst;
        e_pc[k]   = mfront(k).pc;
      end else begin
        e_inst[k] = NOP_INST;
        e_pc[k]   = m_last[k];
      end
    end
  endtask

  task automatic drive(input bit r, input bit v, input bit f, input bit rd,
                       input logic [ADDR_W-1:0] p, input logic [DATA_W-1:0] i);
    rst = r; valid = v; flush = f; rdy = rd; pc = p; inst = i;
    settle();
  endtask

  // Advance one clock and apply the same edge to the model
  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      bit do_pop, do_push;
      if (!rst) begin
        if (k == 0) q0.delete(); else q1.delete();
        m_last[k] = '0;
      end else begin
        m_last[k] = e_pc[k];
        if (flush) begin
          if (k == 0) q0.delete(); else q1.delete();
        end else begin
          do_pop  = e_valid[k] && rdy && !e_byp[k];
          do_push = valid && e_ready[k] && !(e_byp[k] && rdy);
          if (do_pop) begin
            if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
          end
          if (do_push) begin
            if (k == 0) q0.push_back('{pc: pc, inst: inst});
            else        q1.push_back('{pc: pc, inst: inst});
          end
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h100, 32'hDEAD);
    tick();
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h104, 32'hDEAD);
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (o_valid[k] !== e_valid[k]) begin
        miscompares++;
        $display("FAIL reset_valid k=%0d got %b want %b", k, o_valid[k], e_valid[k]);
      end
      vectors++;
      if (o_count[k] !== 32'd0) begin
        miscompares++;
        $display("FAIL reset_count k=%0d got %0d want 0", k, o_count[k]);
      end
    end
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (o_ready[k] !== 1'b1) begin
        miscompares++;
        $display("FAIL reset_ready k=%0d got %b want 1", k, o_ready[k]);
      end
      vectors++;
      if (o_valid[k] !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_valid_rel k=%0d got %b want 0", k, o_valid[k]);
      end
      vectors++;
      if (o_inst[k] !== 32'h00000013) begin
        miscompares++;
        $display("FAIL reset_inst k=%0d got %h want 00000013", k, o_inst[k]);
      end
      vectors++;
      if (o_pc[k] !== '0) begin
        miscompares++;
        $display("FAIL reset_pc k=%0d got %h want 0", k, o_pc[k]);
      end
    end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 5; i++) begin
      if (i < 3) drive(1'b1, 1'b1, 1'b0, 1'b1, ADDR_W'(i * 4), DATA_W'(32'hA0 + i));
      else       drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if (o_valid[k] !== e_valid[k]) begin
          miscompares++;
          $display("FAIL stream_valid k=%0d c=%0d got %b want %b", k, i, o_valid[k], e_valid[k]);
        end
        vectors++;
        if (o_inst[k] !== e_inst[k]) begin
          miscompares++;
          $display("FAIL stream_inst k=%0d c=%0d got %h want %h", k, i, o_inst[k], e_inst[k]);
        end
        vectors++;
        if (o_pc[k] !== e_pc[k]) begin
          miscompares++;
          $display("FAIL stream_pc k=%0d c=%0d got %h want %h", k, i, o_pc[k], e_pc[k]);
        end
        vectors++;
        if (o_count[k] !== e_count[k] || (!BYP && o_count[k] > 32'd1)) begin
          miscompares++;
          $display("FAIL stream_count k=%0d c=%0d got %0d want %0d", k, i, o_count[k], e_count[k]);
        end
      end
      tick();
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, ADDR_W'(i * 4), DATA_W'(32'hB0 + i));
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if (o_count[k] !== e_count[k] || o_ready[k] !== e_ready[k]) begin
          miscompares++;
          $display("FAIL fill_occ k=%0d c=%0d got cnt=%0d rdy=%b want cnt=%0d rdy=%b",
                   k, i, o_count[k], o_ready[k], e_count[k], e_ready[k]);
        end
      end
      tick();
    end
    // Full: a push alongside a pop must still be refused
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'hC0, 32'hBC);
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (o_ready[k] !== 1'b0) begin
        miscompares++;
        $display("FAIL fill_full_ready k=%0d got %b want 0", k, o_ready[k]);
      end
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if (o_valid[k] !== e_valid[k] || o_pc[k] !== e_pc[k] || o_inst[k] !== e_inst[k]) begin
          miscompares++;
          $display("FAIL fill_drain k=%0d c=%0d got v=%b pc=%h i=%h want v=%b pc=%h i=%h",
                   k, i, o_valid[k], o_pc[k], o_inst[k], e_valid[k], e_pc[k], e_inst[k]);
        end
      end
      tick();
    end
  endtask

  task automatic test_flush();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 32'hC1);
    tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h14, 32'hC2);
    tick();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h20, 32'hC3);
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (o_valid[k] !== 1'b0) begin
        miscompares++;
        $display("FAIL flush_valid k=%0d got %b want 0", k, o_valid[k]);
      end
    end
    tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h24, 32'hC4);
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (o_count[k] !== 32'd0 || (!BYP && o_valid[k] !== 1'b0)) begin
        miscompares++;
        $display("FAIL flush_empty k=%0d got cnt=%0d v=%b want cnt=0", k, o_count[k], o_valid[k]);
      end
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if (o_valid[k] !== e_valid[k] || o_pc[k] !== e_pc[k] ||
            (o_valid[k] === 1'b1 && o_pc[k] === 32'h20)) begin
          miscompares++;
          $display("FAIL flush_after k=%0d c=%0d got v=%b pc=%h want v=%b pc=%h",
                   k, i, o_valid[k], o_pc[k], e_valid[k], e_pc[k]);
        end
      end
      tick();
    end
  endtask

  task automatic test_wrap_random();
    int seq = 0;
    for (int c = 0; c < 400; c++) begin
      bit r, v, f, rd;
      r  = ($urandom_range(0, 96) != 0);
      v  = ($urandom_range(0, 3) != 0);
      f  = ($urandom_range(0, 29) == 0);
      rd = ($urandom_range(0, 2) != 0);
      drive(r, v, f, rd, ADDR_W'(seq * 4), DATA_W'($urandom));
      seq++;
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if (o_valid[k] !== e_valid[k] || o_ready[k] !== e_ready[k] || o_count[k] !== e_count[k]) begin
          miscompares++;
          $display("FAIL rand_ctl k=%0d c=%0d got v=%b r=%b n=%0d want v=%b r=%b n=%0d",
                   k, c, o_valid[k], o_ready[k], o_count[k], e_valid[k], e_ready[k], e_count[k]);
        end
        vectors++;
        if (o_pc[k] !== e_pc[k] || o_inst[k] !== e_inst[k]) begin
          miscompares++;
          $display("FAIL rand_data k=%0d c=%0d got pc=%h i=%h want pc=%h i=%h",
                   k, c, o_pc[k], o_inst[k], e_pc[k], e_inst[k]);
        end
      end
      tick();
    end
  endtask

  task automatic test_bypass();
`ifdef IFQ_BYPASS_EN
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h40, 32'hBEEF);
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (o_valid[k] !== 1'b1 || o_inst[k] !== 32'hBEEF || o_pc[k] !== 32'h40) begin
        miscompares++;
        $display("FAIL bypass_out k=%0d got v=%b i=%h pc=%h want v=1 i=0000beef pc=40",
                 k, o_valid[k], o_inst[k], o_pc[k]);
      end
    end
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (o_count[k] !== 32'd0) begin
        miscompares++;
        $display("FAIL bypass_count k=%0d got %0d want 0", k, o_count[k]);
      end
    end
    tick();
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL timeout vectors=%0d", vectors);
    $fatal(1, "timeout");
  end

  initial begin
    m_last[0] = '0;
    m_last[1] = '0;
    test_reset();
    test_stream();
    test_fill();
    test_flush();
    test_bypass();
    test_wrap_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
